alu_seq_sliced: RTL and testbench

- Multi-cycle ALU that executes one WIDTH-bit operation as a sequence of SLICE-bit steps, one slice per clock.
- One combinational SLICE-bit slice carries the inter-slice carry (or shift-in bit) in a register.
- Datapath successor to the 4-bit lookahead ALU: same 5-bit command encoding and the same carry semantics, at arbitrary width.
- Adds a valid/ready handshake, result flags, and a defined carry_out for RSHFT.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_seq_sliced_if.sv | 29 ++
 rtl/alu_seq_sliced_slice.sv | 55 +++++
 rtl/alu_seq_sliced.sv | 153 +++++++++++++++
 tb/tb_alu_seq_sliced.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU command/control types and opcodes.
// Used by the sliced sequential ALU and the 4-bit lookahead ALU.
package alu_pkg;

  typedef enum logic [1:0] {
    MUX_XOR = 2'b00,
    MUX_AND = 2'b01,
    MUX_OR  = 2'b10,
    MUX_SHR = 2'b11
  } alu_ctrl_int_t;

  typedef struct packed {
    logic          carry_in;
    logic          b_inv;
    logic          carry_dis;
    alu_ctrl_int_t mux;
  } alu_cmd_t;

  typedef struct packed {
    logic          b_inv;
    logic          carry_dis;
    alu_ctrl_int_t mux;
  } alu_ctrl_t;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b11000;
  localparam logic [4:0] OP_COMP = 5'b01000;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_XNOR = 5'b01100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_RSHFT = 5'b00111;

  function automatic alu_ctrl_t to_ctrl(logic [4:0] c);
    alu_cmd_t  cm;
    alu_ctrl_t ct;
    cm = alu_cmd_t'(c);
    ct.b_inv     = cm.b_inv;
    ct.carry_dis = cm.carry_dis;
    ct.mux       = cm.mux;
    return ct;
  endfunction

endpackage

// File: rtl/alu_seq_sliced_if.sv
// Request/response handshake bundle for the sliced ALU.
// slave = ALU side, master = requester side.
interface alu_seq_sliced_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       cmd;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             carry_out;
  logic             res_zero;
  logic             res_all_ones;

  modport slave (
    input  in_valid, cmd, d1, d2, out_ready,
    output in_ready, out_valid, res,
    output carry_out, res_zero, res_all_ones
  );

  modport master (
    output in_valid, cmd, d1, d2, out_ready,
    input  in_ready, out_valid, res,
    input  carry_out, res_zero, res_all_ones
  );
endinterface

// File: rtl/alu_seq_sliced_slice.sv
// Combinational SLICE-bit ALU slice with flattened
// generate/propagate carry lookahead.
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] d1,
  input  logic [SLICE-1:0] d2,
  input  logic             carry_in,
  input  logic             direct_in_top,
  input  alu_ctrl_t        ctrl,
  output logic [SLICE-1:0] res,
  output logic             carry_out,
  output logic             d2_lsb
);

  logic [SLICE-1:0] b;
  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE-1:0] dir;
  logic [SLICE:0]   sh;
  logic [SLICE:0]   c;
  logic             m;

  always_comb begin
    b   = d2 ^ {SLICE{ctrl.b_inv}};
    g   = d1 & b;
    p   = d1 | b;
    sh  = {direct_in_top, d2};
    dir = sh[SLICE:1];
    c   = '0;
    res = '0;
    m   = 1'b0;
    // each carry expanded independently from g/p
    for (int i = 0; i <= SLICE; i++) begin
      c[i] = carry_in;
      for (int j = 0; j < i; j++)
        c[i] = g[j] | (p[j] & c[i]);
    end
    for (int i = 0; i < SLICE; i++) begin
      unique case (ctrl.mux)
        MUX_XOR: m = ~g[i] & p[i];
        MUX_AND: m = g[i];
        MUX_OR:  m = p[i];
        MUX_SHR: m = dir[i];
        default: m = 1'b0;
      endcase
      res[i] = m ^ (c[i] & ~ctrl.carry_dis);
    end
    carry_out = c[SLICE];
    d2_lsb    = d2[0];
  end

endmodule

// File: rtl/alu_seq_sliced.sv
// Multi-cycle ALU: one SLICE-bit step per clock,
// inter-slice carry / shift bit held in carry_q.
module alu_seq_sliced
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input logic            clk,
  input logic            rst_n,
  alu_seq_sliced_if.slave bus
);

  localparam int NS = WIDTH / SLICE;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  alu_ctrl_t        ctrl_q, ctrl_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             ones_q, ones_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             shr;
  logic [IW-1:0]    k;
  logic [SLICE-1:0] sl_a, sl_b, sl_res;
  logic             sl_cout, sl_lsb;
  logic [WIDTH-1:0] res_ins;

  // shifts walk MSB slice first so carry_q feeds the next lower slice
  assign shr  = (ctrl_q.mux == MUX_SHR);
  assign k    = shr ? (LAST - idx_q) : idx_q;
  assign sl_a = a_q[int'(k)*SLICE +: SLICE];
  assign sl_b = b_q[int'(k)*SLICE +: SLICE];

  alu_slice #(.SLICE(SLICE)) u_slice (
    .d1            (sl_a),
    .d2            (sl_b),
    .carry_in      (carry_q),
    .direct_in_top (carry_q),
    .ctrl          (ctrl_q),
    .res           (sl_res),
    .carry_out     (sl_cout),
    .d2_lsb        (sl_lsb)
  );

  always_comb begin
    res_ins = res_q;
    res_ins[int'(k)*SLICE +: SLICE] = sl_res;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    ctrl_d      = ctrl_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    cout_d      = cout_q;
    zero_d      = zero_q;
    ones_d      = ones_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          ctrl_d     = to_ctrl(bus.cmd);
          a_d        = bus.d1;
          b_d        = bus.d2;
          carry_d    = bus.cmd[4];
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        res_d = res_ins;
        idx_d = idx_q + 1'b1;
        if (shr)
          carry_d = sl_lsb;
        else if (!ctrl_q.carry_dis)
          carry_d = sl_cout;
        if (idx_q == LAST) begin
          idx_d       = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
          if (shr)
            cout_d = sl_lsb;
          else
            cout_d = sl_cout & ~ctrl_q.carry_dis;
          zero_d = (res_ins == '0);
          ones_d = &res_ins;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      ctrl_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cout_q      <= 1'b0;
      zero_q      <= 1'b0;
      ones_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      ctrl_q      <= ctrl_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      cout_q      <= cout_d;
      zero_q      <= zero_d;
      ones_q      <= ones_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.res          = res_q;
  assign bus.carry_out    = cout_q;
  assign bus.res_zero     = zero_q;
  assign bus.res_all_ones = ones_q;

endmodule

// File: tb/tb_alu_seq_sliced.sv
// Directed bench for alu_seq_sliced at WIDTH=16, SLICE=4.
// Vector table plus backpressure and mid-run reset sequences.
module tb_alu_seq_sliced;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_seq_sliced_if #(.WIDTH(16)) bus ();

  alu_seq_sliced #(.WIDTH(16), .SLICE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    string      nm;
    logic [4:0] cmd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic       c;
    logic       z;
    logic       o;
  } vec_t;

  vec_t tv[14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic start(input logic [4:0] cmd, input logic [15:0] a,
                       input logic [15:0] b);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.cmd = cmd;
    bus.d1 = a;
    bus.d2 = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.d1 = ~a;
    bus.d2 = ~b;
    bus.cmd = ~cmd;
  endtask

  task automatic finish_op(input string nm, input logic [15:0] r,
                           input logic c, input logic z, input logic o,
                           input int hold);
    int n;
    int unstable;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, "_latency"}, n, 4);
    chk({nm, "_res"}, bus.res, r);
    chk({nm, "_carry"}, bus.carry_out, c);
    chk({nm, "_zero"}, bus.res_zero, z);
    chk({nm, "_ones"}, bus.res_all_ones, o);
    chk({nm, "_inrdy_done"}, bus.in_ready, 0);
    if (hold > 0) begin
      unstable = 0;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (bus.res !== r || bus.carry_out !== c ||
            bus.res_zero !== z || bus.res_all_ones !== o ||
            bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
          unstable++;
      end
      chk({nm, "_hold_stable"}, unstable, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({nm, "_inrdy_after"}, bus.in_ready, 1);
    chk({nm, "_ovalid_after"}, bus.out_valid, 0);
  endtask

  initial begin
    int seen;
    tv[0]  = '{"add_wrap", 5'b00000, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0};
    tv[1]  = '{"sub_neg",  5'b11000, 16'h1234, 16'h1235, 16'hFFFF, 0, 0, 1};
    tv[2]  = '{"sub_pos",  5'b11000, 16'h5000, 16'h1000, 16'h4000, 1, 0, 0};
    tv[3]  = '{"comp_eq",  5'b01000, 16'hABCD, 16'hABCD, 16'hFFFF, 0, 0, 1};
    tv[4]  = '{"comp_gt",  5'b01000, 16'hABCE, 16'hABCD, 16'h0000, 1, 1, 0};
    tv[5]  = '{"shr_in1",  5'b10111, 16'h0000, 16'h8421, 16'hC210, 1, 0, 0};
    tv[6]  = '{"shr_in0",  5'b00111, 16'h0000, 16'h8421, 16'h4210, 1, 0, 0};
    tv[7]  = '{"xor",      5'b00100, 16'h0F0F, 16'h00FF, 16'h0FF0, 0, 0, 0};
    tv[8]  = '{"add_cin",  5'b10000, 16'h1234, 16'h0001, 16'h1236, 0, 0, 0};
    tv[9]  = '{"and",      5'b00101, 16'hF0F0, 16'hFF00, 16'hF000, 0, 0, 0};
    tv[10] = '{"or",       5'b00110, 16'hF0F0, 16'h0F00, 16'hFFF0, 0, 0, 0};
    tv[11] = '{"xnor",     5'b01100, 16'hF0F0, 16'hFF00, 16'hF00F, 0, 0, 0};
    tv[12] = '{"xor_cin",  5'b10100, 16'h1234, 16'h1234, 16'h0000, 0, 1, 0};
    tv[13] = '{"add_mid",  5'b00000, 16'h7FFF, 16'h0001, 16'h8000, 0, 0, 0};

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.cmd = '0;
    bus.d1 = '0;
    bus.d2 = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_res", bus.res, 0);
    chk("rst_flags", {bus.carry_out, bus.res_zero, bus.res_all_ones}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      start(tv[i].cmd, tv[i].a, tv[i].b);
      finish_op(tv[i].nm, tv[i].r, tv[i].c, tv[i].z, tv[i].o, 0);
    end

    // backpressure: hold DONE for 5 cycles, then a fresh request
    start(5'b11000, 16'h5000, 16'h1000);
    finish_op("bp_sub", 16'h4000, 1'b1, 1'b0, 1'b0, 5);
    start(5'b00000, 16'h0102, 16'h0304);
    finish_op("bp_next", 16'h0406, 1'b0, 1'b0, 1'b0, 0);

    // reset while RUN is on slice 2
    start(5'b00000, 16'h1111, 16'h2222);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_res", bus.res, 0);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("midrst_no_result", seen, 0);
    start(5'b00100, 16'h0F0F, 16'h00FF);
    finish_op("post_rst_xor", 16'h0FF0, 1'b0, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
